// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : IF-stage fetch sequencer: imem req/ack handshake, PC advance
//            timing, buffered branch redirects and wrong-path squash.
// Revision : 1.0
// ============================================================================
module fetch_sequencer_if #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        pc_enable,
    output logic        redir_out_valid,
    output logic [31:0] redir_out_addr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        ifid_flush,
    output logic        fetch_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [7:0] c_TIMEOUT_CNT = TIMEOUT[7:0];

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_pend_v;
    logic [31:0] r_pend_addr;
    logic [7:0]  r_wait_cnt;
    logic        w_eff_redir;
    logic [31:0] w_eff_addr;
    logic        w_take_redir;
    logic        w_capture;

    // A buffered redirect outranks a fresh one: the first redirect wins.
    assign w_eff_redir = r_pend_v | redir_valid;
    assign w_eff_addr  = r_pend_v ? r_pend_addr : redir_addr;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ack && !w_eff_redir && stall) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_eff_redir || !stall) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req        = 1'b0;
        imem_addr       = 32'd0;
        pc_enable       = 1'b0;
        redir_out_valid = 1'b0;
        redir_out_addr  = 32'd0;
        ifid_flush      = 1'b0;
        w_take_redir    = 1'b0;
        w_capture       = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (imem_ack) begin
                    if (w_eff_redir) begin
                        w_take_redir = 1'b1;
                    end else begin
                        w_capture = 1'b1;
                        pc_enable = !stall;
                    end
                end
            end
            S_HOLD: begin
                if (w_eff_redir) begin
                    w_take_redir = 1'b1;
                end else begin
                    pc_enable = !stall;
                end
            end
            default: ;
        endcase
        if (w_take_redir) begin
            pc_enable       = 1'b1;
            redir_out_valid = 1'b1;
            redir_out_addr  = w_eff_addr;
            ifid_flush      = 1'b1;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_instr <= 32'd0;
            if_pc    <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_capture) begin
                        if_valid <= 1'b1;
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                    end else if (w_take_redir) begin
                        if_valid <= 1'b0;
                    end else begin
                        // Keep an instruction that ID is still stalling on.
                        if_valid <= if_valid & stall;
                    end
                end
                S_HOLD: begin
                    if (w_take_redir || !stall) begin
                        if_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'd0;
        end else if (w_take_redir) begin
            r_pend_v <= 1'b0;
        end else if (redir_valid && !r_pend_v) begin
            r_pend_v    <= 1'b1;
            r_pend_addr <= redir_addr;
        end
    end

    // Watchdog saturates at the limit; the fetch itself keeps waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
            fetch_err  <= 1'b0;
        end else if (r_state == S_FETCH) begin
            if (imem_ack) begin
                r_wait_cnt <= 8'd0;
            end else begin
                if (r_wait_cnt != c_TIMEOUT_CNT) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end else begin
                    fetch_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer_if
// Brief    : Directed self-checking bench for fetch_sequencer_if.
// Revision : 1.0
// ============================================================================
module tb_fetch_sequencer_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_enable;
    logic        redir_out_valid;
    logic [31:0] redir_out_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        ifid_flush;
    logic        fetch_err;

    logic        pc_ld_en;
    logic [31:0] pc_ld_val;

    int n_vec = 0;
    int n_err = 0;

    fetch_sequencer_if #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .pc(pc), .stall(stall),
        .redir_valid(redir_valid), .redir_addr(redir_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_enable(pc_enable), .redir_out_valid(redir_out_valid),
        .redir_out_addr(redir_out_addr), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .ifid_flush(ifid_flush),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // PC register driven by the sequencer, with a bench-side preload.
    always @(posedge clk or posedge reset) begin
        if (reset)               pc <= 32'd0;
        else if (pc_ld_en)       pc <= pc_ld_val;
        else if (pc_enable)      pc <= redir_out_valid ? redir_out_addr : pc + 32'd4;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_addr = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0; pc_ld_en = 1'b0; pc_ld_val = 32'd0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_pcen", pc_enable, 0);
        chk("rst_rov", redir_out_valid, 0);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_ifv", if_valid, 0);
        chk("rst_err", fetch_err, 0);
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk("idle_req", imem_req, 0);
        chk("idle_pcen", pc_enable, 0);
        cyc();

        // zero-wait streaming
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = 32'hA000_0000 | (i * 4);
            #1;
            chk("zw_addr", imem_addr, i * 4);
            chk("zw_req", imem_req, 1);
            chk("zw_pcen", pc_enable, 1);
            cyc();
            chk("zw_ifpc", if_pc, i * 4);
            chk("zw_ifv", if_valid, 1);
            chk("zw_instr", if_instr, 32'hA000_0000 | (i * 4));
        end

        // 3-cycle wait at 0x40
        imem_ack = 1'b0; pc_ld_en = 1'b1; pc_ld_val = 32'h40;
        cyc();
        pc_ld_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("w3_addr", imem_addr, 32'h40);
            chk("w3_pcen", pc_enable, 0);
            cyc();
            chk("w3_ifv", if_valid, 0);
        end
        imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
        #1;
        chk("w3_addr3", imem_addr, 32'h40);
        chk("w3_pcen3", pc_enable, 1);
        chk("w3_rov3", redir_out_valid, 0);
        cyc();
        chk("w3_instr", if_instr, 32'h8C22_0004);
        chk("w3_ifpc", if_pc, 32'h40);
        chk("w3_ifv", if_valid, 1);

        // stall then release
        stall = 1'b1; imem_rdata = 32'h1111_1111;
        #1;
        chk("st_addr", imem_addr, 32'h44);
        chk("st_pcen", pc_enable, 0);
        cyc();
        imem_ack = 1'b0;
        chk("st_ifv", if_valid, 1);
        chk("st_ifpc", if_pc, 32'h44);
        chk("st_instr", if_instr, 32'h1111_1111);
        chk("st_req", imem_req, 0);
        chk("st_pcen2", pc_enable, 0);
        cyc();
        chk("st_ifv2", if_valid, 1);
        chk("st_ifpc2", if_pc, 32'h44);
        stall = 1'b0;
        #1;
        chk("st_rel_pcen", pc_enable, 1);
        chk("st_rel_rov", redir_out_valid, 0);
        chk("st_rel_flush", ifid_flush, 0);
        cyc();
        chk("st_rel_ifv", if_valid, 0);
        chk("st_rel_addr", imem_addr, 32'h48);

        // redirect while waiting: first redirect wins
        redir_valid = 1'b1; redir_addr = 32'h100;
        #1;
        chk("rw_pcen1", pc_enable, 0);
        cyc();
        redir_addr = 32'h200;
        #1;
        chk("rw_pcen2", pc_enable, 0);
        cyc();
        redir_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rw_pcen", pc_enable, 1);
        chk("rw_rov", redir_out_valid, 1);
        chk("rw_roa", redir_out_addr, 32'h100);
        chk("rw_flush", ifid_flush, 1);
        cyc();
        chk("rw_ifv", if_valid, 0);
        chk("rw_addr", imem_addr, 32'h100);

        // redirect beats stall in HOLD
        stall = 1'b1; imem_rdata = 32'h2222_2222;
        cyc();
        chk("rs_ifv", if_valid, 1);
        imem_ack = 1'b0; redir_valid = 1'b1; redir_addr = 32'h300;
        #1;
        chk("rs_flush", ifid_flush, 1);
        chk("rs_pcen", pc_enable, 1);
        chk("rs_roa", redir_out_addr, 32'h300);
        cyc();
        chk("rs_ifv2", if_valid, 0);
        chk("rs_addr", imem_addr, 32'h300);

        // redirect and ack together: nothing left pending
        stall = 1'b0; imem_ack = 1'b1; redir_addr = 32'h400;
        #1;
        chk("ra_roa", redir_out_addr, 32'h400);
        chk("ra_flush", ifid_flush, 1);
        cyc();
        redir_valid = 1'b0; imem_rdata = 32'h3333_3333;
        #1;
        chk("ra_addr", imem_addr, 32'h400);
        chk("ra_rov", redir_out_valid, 0);
        chk("ra_pcen", pc_enable, 1);
        cyc();
        chk("ra_ifpc", if_pc, 32'h400);
        chk("ra_err", fetch_err, 0);

        // timeout then reset mid-wait
        imem_ack = 1'b0;
        cyc(); cyc(); cyc();
        chk("to_err3", fetch_err, 0);
        cyc(); cyc();
        chk("to_err5", fetch_err, 1);
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        chk("to_sticky", fetch_err, 1);
        cyc();
        reset = 1'b1;
        #1;
        chk("rm_req", imem_req, 0);
        chk("rm_ifv", if_valid, 0);
        chk("rm_ifpc", if_pc, 0);
        chk("rm_instr", if_instr, 0);
        chk("rm_err", fetch_err, 0);
        chk("rm_pcen", pc_enable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
